// File: rtl/bcd_date_sequencer.sv
// bcd_date_sequencer: BCD calendar date advanced one day per tick, loadable through a validated handshake.
// Contains the LeapYear helper block used on the next-year value, the shadow year and the reset year.
module leap_year (
  input  logic [15:0] year,
  output logic        leap
);
  logic [1:0] lo_mod, hi_mod;
  // (10*a + b) mod 4 == (2*a + b) mod 4, so only the low bits of each digit matter
  always_comb begin
    lo_mod = {year[4], 1'b0} + year[1:0];
    hi_mod = {year[12], 1'b0} + year[9:8];
    leap   = (year[7:0] == 8'h00) ? (hi_mod == 2'd0) : (lo_mod == 2'd0);
  end
endmodule

module bcd_date_sequencer #(
  parameter logic [15:0] RESET_YEAR  = 16'h2000,
  parameter logic [7:0]  RESET_MONTH = 8'h01,
  parameter logic [7:0]  RESET_DAY   = 8'h01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [15:0] ld_year,
  input  logic [7:0]  ld_month,
  input  logic [7:0]  ld_day,
  output logic [15:0] year,
  output logic [7:0]  month,
  output logic [7:0]  day,
  output logic        leap,
  output logic        ld_err,
  output logic        yr_wrap
);
  typedef enum logic {IDLE, CHECK} state_t;

  state_t      state_q, state_d;
  logic [15:0] year_q, year_d, sh_year_q, sh_year_d;
  logic [7:0]  month_q, month_d, sh_month_q, sh_month_d;
  logic [7:0]  day_q, day_d, sh_day_q, sh_day_d;
  logic        leap_q, leap_d, ld_err_q, ld_err_d, yr_wrap_q, yr_wrap_d, ld_ready_q, ld_ready_d;
  logic [15:0] next_year;
  logic        next_leap, sh_leap, rst_leap;
  logic        last_day, year_end, nib_ok, sh_ok;
  logic [31:0] sh_all;

  function automatic logic [7:0] month_len(input logic [7:0] m, input logic lp);
    month_len = (m == 8'h02) ? (lp ? 8'h29 : 8'h28) :
                (m == 8'h04 || m == 8'h06 || m == 8'h09 || m == 8'h11) ? 8'h30 : 8'h31;
  endfunction

  function automatic logic [7:0] bcd_inc8(input logic [7:0] v);
    bcd_inc8 = (v[3:0] == 4'h9) ? {v[7:4] + 4'd1, 4'h0} : v + 8'd1;
  endfunction

  function automatic logic [15:0] bcd_inc16(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i+:4] == 4'h9) r[4*i+:4] = 4'h0;
        else begin
          r[4*i+:4] = r[4*i+:4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  leap_year u_next_leap (.year(next_year),  .leap(next_leap));
  leap_year u_sh_leap   (.year(sh_year_q),  .leap(sh_leap));
  leap_year u_rst_leap  (.year(RESET_YEAR), .leap(rst_leap));

  always_comb begin
    next_year = bcd_inc16(year_q);
    last_day  = day_q >= month_len(month_q, leap_q);
    year_end  = month_q == 8'h12;
    sh_all    = {sh_year_q, sh_month_q, sh_day_q};
    nib_ok    = 1'b1;
    for (int i = 0; i < 8; i++)
      if (sh_all[4*i+:4] > 4'h9) nib_ok = 1'b0;
    sh_ok = nib_ok && sh_month_q >= 8'h01 && sh_month_q <= 8'h12 && sh_day_q >= 8'h01 &&
            sh_day_q <= month_len(sh_month_q, sh_leap);
  end

  always_comb begin
    state_d    = state_q;
    year_d     = year_q;
    month_d    = month_q;
    day_d      = day_q;
    leap_d     = leap_q;
    sh_year_d  = sh_year_q;
    sh_month_d = sh_month_q;
    sh_day_d   = sh_day_q;
    ld_err_d   = 1'b0;
    yr_wrap_d  = 1'b0;
    if (state_q == IDLE) begin
      if (ld_valid && ld_ready_q) begin
        sh_year_d  = ld_year;
        sh_month_d = ld_month;
        sh_day_d   = ld_day;
        state_d    = CHECK;
      end else if (tick) begin
        day_d     = last_day ? 8'h01 : bcd_inc8(day_q);
        month_d   = last_day ? (year_end ? 8'h01 : bcd_inc8(month_q)) : month_q;
        year_d    = (last_day && year_end) ? next_year : year_q;
        leap_d    = (last_day && year_end) ? next_leap : leap_q;
        yr_wrap_d = last_day && year_end && year_q == 16'h9999;
      end
    end else begin
      year_d   = sh_ok ? sh_year_q : year_q;
      month_d  = sh_ok ? sh_month_q : month_q;
      day_d    = sh_ok ? sh_day_q : day_q;
      leap_d   = sh_ok ? sh_leap : leap_q;
      ld_err_d = !sh_ok;
      state_d  = IDLE;
    end
    ld_ready_d = state_d == IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      year_q     <= RESET_YEAR;
      month_q    <= RESET_MONTH;
      day_q      <= RESET_DAY;
      leap_q     <= rst_leap;
      sh_year_q  <= 16'h0000;
      sh_month_q <= 8'h00;
      sh_day_q   <= 8'h00;
      ld_err_q   <= 1'b0;
      yr_wrap_q  <= 1'b0;
      ld_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      year_q     <= year_d;
      month_q    <= month_d;
      day_q      <= day_d;
      leap_q     <= leap_d;
      sh_year_q  <= sh_year_d;
      sh_month_q <= sh_month_d;
      sh_day_q   <= sh_day_d;
      ld_err_q   <= ld_err_d;
      yr_wrap_q  <= yr_wrap_d;
      ld_ready_q <= ld_ready_d;
    end
  end

  assign year     = year_q;
  assign month    = month_q;
  assign day      = day_q;
  assign leap     = leap_q;
  assign ld_err   = ld_err_q;
  assign yr_wrap  = yr_wrap_q;
  assign ld_ready = ld_ready_q;
endmodule

// File: tb/tb_bcd_date_sequencer.sv
// tb_bcd_date_sequencer: directed checks of date advance, leap handling, load validation and reset.
module tb_bcd_date_sequencer;
  logic        clk, rst_n, tick, ld_valid, ld_ready, leap, ld_err, yr_wrap;
  logic [15:0] ld_year, year;
  logic [7:0]  ld_month, ld_day, month, day;
  int          n_vec, n_err;

  bcd_date_sequencer dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_year(ld_year), .ld_month(ld_month), .ld_day(ld_day),
    .year(year), .month(month), .day(day), .leap(leap), .ld_err(ld_err), .yr_wrap(yr_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_date(input string tag, input logic [15:0] y, input logic [7:0] m, input logic [7:0] d,
                          input logic lp);
    chk({tag, ".year"}, year, y);
    chk({tag, ".month"}, {8'h00, month}, {8'h00, m});
    chk({tag, ".day"}, {8'h00, day}, {8'h00, d});
    chk({tag, ".leap"}, {15'd0, leap}, {15'd0, lp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // handshake edge only; the caller observes the CHECK cycle
  task automatic hs(input logic [15:0] y, input logic [7:0] m, input logic [7:0] d, input logic t);
    ld_valid = 1'b1;
    ld_year  = y;
    ld_month = m;
    ld_day   = d;
    tick     = t;
    step();
    ld_valid = 1'b0;
    tick     = 1'b0;
  endtask

  task automatic load_ok(input string tag, input logic [15:0] y, input logic [7:0] m, input logic [7:0] d,
                         input logic lp);
    hs(y, m, d, 1'b0);
    chk({tag, ".ready_in_check"}, {15'd0, ld_ready}, 16'd0);
    step();
    chk_date(tag, y, m, d, lp);
    chk({tag, ".err"}, {15'd0, ld_err}, 16'd0);
    chk({tag, ".ready"}, {15'd0, ld_ready}, 16'd1);
  endtask

  task automatic load_bad(input string tag, input logic [15:0] y, input logic [7:0] m, input logic [7:0] d,
                          input logic [15:0] cy, input logic [7:0] cm, input logic [7:0] cd, input logic clp);
    hs(y, m, d, 1'b0);
    chk({tag, ".err_early"}, {15'd0, ld_err}, 16'd0);
    step();
    chk({tag, ".err"}, {15'd0, ld_err}, 16'd1);
    chk_date(tag, cy, cm, cd, clp);
    step();
    chk({tag, ".err_drop"}, {15'd0, ld_err}, 16'd0);
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    tick = 1'b0;
    ld_valid = 1'b0;
    ld_year = 16'h0;
    ld_month = 8'h0;
    ld_day = 8'h0;
    #12;
    chk_date("rst_held", 16'h2000, 8'h01, 8'h01, 1'b1);
    chk("rst_held.ready", {15'd0, ld_ready}, 16'd1);
    rst_n = 1'b1;
    step();
    chk_date("rst", 16'h2000, 8'h01, 8'h01, 1'b1);
    chk("rst.ready", {15'd0, ld_ready}, 16'd1);
    chk("rst.err", {15'd0, ld_err}, 16'd0);
    chk("rst.wrap", {15'd0, yr_wrap}, 16'd0);

    load_ok("ld1900", 16'h1900, 8'h02, 8'h28, 1'b0);
    do_tick();
    chk_date("t1900", 16'h1900, 8'h03, 8'h01, 1'b0);

    load_ok("ld2000", 16'h2000, 8'h02, 8'h28, 1'b1);
    do_tick();
    chk_date("t2000a", 16'h2000, 8'h02, 8'h29, 1'b1);
    do_tick();
    chk_date("t2000b", 16'h2000, 8'h03, 8'h01, 1'b1);

    load_ok("ld9999", 16'h9999, 8'h12, 8'h31, 1'b0);
    chk("ld9999.wrap", {15'd0, yr_wrap}, 16'd0);
    do_tick();
    chk_date("wrap", 16'h0000, 8'h01, 8'h01, 1'b1);
    chk("wrap.pulse", {15'd0, yr_wrap}, 16'd1);
    step();
    chk("wrap.drop", {15'd0, yr_wrap}, 16'd0);
    chk_date("wrap.hold", 16'h0000, 8'h01, 8'h01, 1'b1);

    load_bad("bad0229", 16'h2023, 8'h02, 8'h29, 16'h0000, 8'h01, 8'h01, 1'b1);
    load_bad("bad_m13", 16'h2023, 8'h13, 8'h01, 16'h0000, 8'h01, 8'h01, 1'b1);
    load_bad("bad_d0a", 16'h2023, 8'h01, 8'h0A, 16'h0000, 8'h01, 8'h01, 1'b1);
    load_bad("bad_0431", 16'h2023, 8'h04, 8'h31, 16'h0000, 8'h01, 8'h01, 1'b1);
    load_bad("bad_d00", 16'h2023, 8'h04, 8'h00, 16'h0000, 8'h01, 8'h01, 1'b1);

    hs(16'h2024, 8'h02, 8'h28, 1'b1);
    chk_date("race.hs", 16'h0000, 8'h01, 8'h01, 1'b1);
    chk("race.ready", {15'd0, ld_ready}, 16'd0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk_date("race.commit", 16'h2024, 8'h02, 8'h28, 1'b1);
    do_tick();
    chk_date("t2024a", 16'h2024, 8'h02, 8'h29, 1'b1);
    do_tick();
    chk_date("t2024b", 16'h2024, 8'h03, 8'h01, 1'b1);

    load_ok("ld0309", 16'h2024, 8'h03, 8'h09, 1'b1);
    do_tick();
    chk_date("d09", 16'h2024, 8'h03, 8'h10, 1'b1);
    load_ok("ld0930", 16'h2023, 8'h09, 8'h30, 1'b0);
    do_tick();
    chk_date("m09", 16'h2023, 8'h10, 8'h01, 1'b0);
    load_ok("ld1999", 16'h1999, 8'h12, 8'h31, 1'b0);
    do_tick();
    chk_date("y1999", 16'h2000, 8'h01, 8'h01, 1'b1);
    chk("y1999.wrap", {15'd0, yr_wrap}, 16'd0);
    load_ok("ld0999", 16'h0999, 8'h12, 8'h31, 1'b0);
    do_tick();
    chk_date("y0999", 16'h1000, 8'h01, 8'h01, 1'b0);

    hs(16'h2024, 8'h04, 8'h30, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_date("midrst", 16'h2000, 8'h01, 8'h01, 1'b1);
    chk("midrst.ready", {15'd0, ld_ready}, 16'd1);
    chk("midrst.err", {15'd0, ld_err}, 16'd0);
    #1 rst_n = 1'b1;
    step();
    chk_date("midrst.after", 16'h2000, 8'h01, 8'h01, 1'b1);
    chk("midrst.after_err", {15'd0, ld_err}, 16'd0);
    chk("midrst.after_ready", {15'd0, ld_ready}, 16'd1);
    do_tick();
    chk_date("midrst.tick", 16'h2000, 8'h01, 8'h02, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
